ldm_stm_sequencer: RTL and testbench



---
 rtl/mem_pkg.sv | 54 +++++
 rtl/ldm_stm_sequencer_if.sv | 26 ++
 rtl/reg_list_encoder.sv | 30 +++
 rtl/ldm_stm_sequencer.sv | 163 ++++++++++++++++
 tb/tb_ldm_stm_sequencer.sv | 328 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_pkg.sv
// Shared load/store opcodes, register indices and sequencer types for the
// multi-word transfer path and the data memory.
package mem_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned LIST_W = 9;
    localparam int unsigned IDX_W  = 4;
    localparam int unsigned OP_W   = 7;

    localparam logic [OP_W-1:0] STORE_WORD     = 7'b0101000;
    localparam logic [OP_W-1:0] LOAD_WORD      = 7'b0101100;
    localparam logic [OP_W-1:0] PUSH           = 7'b1011010;
    localparam logic [OP_W-1:0] POP            = 7'b1011110;
    // Low two bits of the multiple-transfer encodings carry Rn and are ignored
    localparam logic [OP_W-1:0] STORE_MULTIPLE = 7'b1100000;
    localparam logic [OP_W-1:0] LOAD_MULTIPLE  = 7'b1100100;

    localparam logic [IDX_W-1:0] SP = 4'd13;
    localparam logic [IDX_W-1:0] LR = 4'd14;
    localparam logic [IDX_W-1:0] PC = 4'd15;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCESS,
        S_DRAIN,
        S_WB
    } seq_state_e;

    typedef enum logic [2:0] {
        MOP_NONE,
        MOP_PUSH,
        MOP_POP,
        MOP_STM,
        MOP_LDM
    } mop_e;

    function automatic mop_e decode_op(input logic [OP_W-1:0] op);
        mop_e m;
        m = MOP_NONE;
        casez (op)
            PUSH: m = MOP_PUSH;
            POP:  m = MOP_POP;
            default: begin
                if (op[6:2] == STORE_MULTIPLE[6:2]) begin
                    m = MOP_STM;
                end else if (op[6:2] == LOAD_MULTIPLE[6:2]) begin
                    m = MOP_LDM;
                end
            end
        endcase
        return m;
    endfunction

endpackage

// File: rtl/ldm_stm_sequencer_if.sv
// Single-word data memory port driven by the multi-word transfer sequencer.
interface ldm_stm_sequencer_if
    import mem_pkg::*;
();
    logic [DATA_W-1:0] mem_addr;
    logic              mem_write_en;
    logic [OP_W-1:0]   mem_op_code;
    logic [DATA_W-1:0] mem_data_in;
    logic [DATA_W-1:0] mem_data_out;

    modport master (
        output mem_addr,
        output mem_write_en,
        output mem_op_code,
        output mem_data_in,
        input  mem_data_out
    );

    modport slave (
        input  mem_addr,
        input  mem_write_en,
        input  mem_op_code,
        input  mem_data_in,
        output mem_data_out
    );
endinterface

// File: rtl/reg_list_encoder.sv
// Combinational register-list helpers: lowest set bit, its one-hot mask and popcount.
module reg_list_encoder
    import mem_pkg::*;
(
    input  logic [LIST_W-1:0] list,
    output logic [IDX_W-1:0]  low_idx,
    output logic [LIST_W-1:0] clear_mask,
    output logic [IDX_W-1:0]  count
);

    // Scan downward so the last hit is the lowest set bit
    always_comb begin
        low_idx    = '0;
        clear_mask = '0;
        for (int i = int'(LIST_W) - 1; i >= 0; i--) begin
            if (list[i]) begin
                low_idx    = IDX_W'(i);
                clear_mask = LIST_W'(1) << i;
            end
        end
    end

    always_comb begin
        count = '0;
        for (int i = 0; i < int'(LIST_W); i++) begin
            count = count + IDX_W'(list[i]);
        end
    end

endmodule

// File: rtl/ldm_stm_sequencer.sv
// MEM-stage sequencer expanding PUSH/POP/STM/LDM into single-word accesses,
// register-file load writes and a final base-register writeback.
module ldm_stm_sequencer
    import mem_pkg::*;
#(
    parameter int unsigned ADDR_STEP = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [OP_W-1:0]    op_code,
    input  logic [LIST_W-1:0]  reg_list,
    input  logic [2:0]         rn_idx,
    input  logic [DATA_W-1:0]  base_val,
    output logic               busy,
    output logic               done,
    output logic [IDX_W-1:0]   reg_rd_idx,
    input  logic [DATA_W-1:0]  reg_rd_data,
    output logic               rf_we,
    output logic [IDX_W-1:0]   rf_wr_idx,
    output logic [DATA_W-1:0]  rf_wr_data,
    output logic               pc_load,
    ldm_stm_sequencer_if.master mem
);

    seq_state_e        state_q, state_d;
    mop_e              op_dec, kind_q;
    logic              start_ok, is_load, last_word;
    logic              pend_valid_q, skip_wb_q;
    logic [LIST_W-1:0] list_in, list_q, enc_list, enc_clear;
    logic [IDX_W-1:0]  enc_idx, enc_count, count_q, cur_reg, pend_idx_q, base_idx;
    logic [2:0]        rn_q;
    logic [DATA_W-1:0] base_q, addr_q, start_addr, span_in, span_q, wb_val;

    assign op_dec   = decode_op(op_code);
    assign start_ok = start && (state_q == S_IDLE) && (op_dec != MOP_NONE);

    // Bit 8 only has meaning for PUSH (LR) and POP (PC)
    assign list_in  = (op_dec == MOP_PUSH || op_dec == MOP_POP) ? reg_list
                                                                : {1'b0, reg_list[7:0]};
    // One encoder: popcount of the incoming list in IDLE, working list otherwise
    assign enc_list = (state_q == S_IDLE) ? list_in : list_q;

    reg_list_encoder u_enc (
        .list       (enc_list),
        .low_idx    (enc_idx),
        .clear_mask (enc_clear),
        .count      (enc_count)
    );

    assign span_in    = DATA_W'(enc_count) << 2;
    assign start_addr = (op_dec == MOP_PUSH) ? base_val - span_in : base_val;

    assign is_load   = (kind_q == MOP_POP) || (kind_q == MOP_LDM);
    assign cur_reg   = (enc_idx == IDX_W'(8)) ? ((kind_q == MOP_POP) ? PC : LR) : enc_idx;
    assign last_word = (list_q & ~enc_clear) == '0;

    assign span_q   = DATA_W'(count_q) << 2;
    assign wb_val   = (kind_q == MOP_PUSH) ? base_q - span_q : base_q + span_q;
    assign base_idx = (kind_q == MOP_PUSH || kind_q == MOP_POP) ? SP : {1'b0, rn_q};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Working list, address and pending load-write tracking
    always_ff @(posedge clk) begin
        if (rst) begin
            kind_q       <= MOP_NONE;
            list_q       <= '0;
            base_q       <= '0;
            addr_q       <= '0;
            count_q      <= '0;
            rn_q         <= '0;
            skip_wb_q    <= 1'b0;
            pend_valid_q <= 1'b0;
            pend_idx_q   <= '0;
        end else begin
            pend_valid_q <= (state_q == S_ACCESS) && is_load;
            pend_idx_q   <= cur_reg;
            if (start_ok) begin
                kind_q    <= op_dec;
                list_q    <= list_in;
                base_q    <= base_val;
                addr_q    <= start_addr;
                count_q   <= enc_count;
                rn_q      <= rn_idx;
                // Empty list, or LDM that loads its own base: the base is left alone
                skip_wb_q <= (enc_count == '0) || (op_dec == MOP_LDM && reg_list[rn_idx]);
            end else if (state_q == S_ACCESS) begin
                list_q <= list_q & ~enc_clear;
                addr_q <= addr_q + DATA_W'(ADDR_STEP);
            end
        end
    end

    always_comb begin
        state_d          = state_q;
        busy             = start_ok || (state_q != S_IDLE);
        done             = 1'b0;
        reg_rd_idx       = '0;
        rf_we            = 1'b0;
        rf_wr_idx        = '0;
        rf_wr_data       = '0;
        pc_load          = 1'b0;
        mem.mem_addr     = '0;
        mem.mem_write_en = 1'b0;
        mem.mem_op_code  = LOAD_WORD;
        mem.mem_data_in  = '0;

        case (state_q)
            S_IDLE: begin
                if (start_ok) begin
                    state_d = (enc_count == '0) ? S_WB : S_ACCESS;
                end
            end
            S_ACCESS: begin
                mem.mem_addr = addr_q;
                if (is_load) begin
                    // Load data lags its address by a cycle
                    if (pend_valid_q) begin
                        rf_we      = 1'b1;
                        rf_wr_idx  = pend_idx_q;
                        rf_wr_data = mem.mem_data_out;
                        pc_load    = (pend_idx_q == PC);
                    end
                end else begin
                    mem.mem_op_code  = STORE_WORD;
                    mem.mem_write_en = 1'b1;
                    reg_rd_idx       = cur_reg;
                    mem.mem_data_in  = reg_rd_data;
                end
                if (last_word) begin
                    state_d = is_load ? S_DRAIN : S_WB;
                end
            end
            S_DRAIN: begin
                if (pend_valid_q) begin
                    rf_we      = 1'b1;
                    rf_wr_idx  = pend_idx_q;
                    rf_wr_data = mem.mem_data_out;
                    pc_load    = (pend_idx_q == PC);
                end
                state_d = S_WB;
            end
            S_WB: begin
                done = 1'b1;
                if (!skip_wb_q) begin
                    rf_we      = 1'b1;
                    rf_wr_idx  = base_idx;
                    rf_wr_data = wb_val;
                end
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_ldm_stm_sequencer.sv
// Scoreboard bench for ldm_stm_sequencer with a memory and register-file model.
module tb_ldm_stm_sequencer;

    logic        clk = 1'b0;
    logic        rst, start;
    logic [6:0]  op_code;
    logic [8:0]  reg_list;
    logic [2:0]  rn_idx;
    logic [31:0] base_val;
    logic        busy, done, rf_we, pc_load;
    logic [3:0]  reg_rd_idx, rf_wr_idx;
    logic [31:0] reg_rd_data, rf_wr_data;

    logic [31:0] mem [0:255];
    logic [31:0] rf  [0:15];
    logic        pm_we, pr_we;
    logic [31:0] p_addr, p_data;
    logic [3:0]  p_idx;

    int tests = 0;
    int fails = 0;

    localparam logic [6:0] OP_PUSH = 7'b1011010;
    localparam logic [6:0] OP_POP  = 7'b1011110;
    localparam logic [6:0] OP_LW   = 7'b0101100;

    typedef struct {
        int          kind;   // 0 mem write, 1 rf write, 2 done
        int          cyc;
        logic [31:0] a;
        logic [31:0] d;
        logic        pc;
    } ev_t;
    ev_t sb[$];

    always #5 clk = ~clk;

    ldm_stm_sequencer_if mif ();

    ldm_stm_sequencer #(.ADDR_STEP(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .op_code     (op_code),
        .reg_list    (reg_list),
        .rn_idx      (rn_idx),
        .base_val    (base_val),
        .busy        (busy),
        .done        (done),
        .reg_rd_idx  (reg_rd_idx),
        .reg_rd_data (reg_rd_data),
        .rf_we       (rf_we),
        .rf_wr_idx   (rf_wr_idx),
        .rf_wr_data  (rf_wr_data),
        .pc_load     (pc_load),
        .mem         (mif)
    );

    assign reg_rd_data = rf[reg_rd_idx];

    always @(posedge clk) begin
        if (mif.mem_write_en) mem[mif.mem_addr[9:2]] <= mif.mem_data_in;
        if (pm_we) mem[p_addr[9:2]] <= p_data;
        mif.mem_data_out <= mem[mif.mem_addr[9:2]];
        if (rf_we) rf[rf_wr_idx] <= rf_wr_data;
        if (pr_we) rf[p_idx] <= p_data;
    end

    task automatic poke_mem(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk); pm_we = 1'b1; p_addr = a; p_data = d;
        @(negedge clk); pm_we = 1'b0;
    endtask

    task automatic poke_rf(input logic [3:0] i, input logic [31:0] d);
        @(negedge clk); pr_we = 1'b1; p_idx = i; p_data = d;
        @(negedge clk); pr_we = 1'b0;
    endtask

    task automatic exp_memw(input int c, input logic [31:0] a, input logic [31:0] d);
        ev_t e; e.kind = 0; e.cyc = c; e.a = a; e.d = d; e.pc = 1'b0; sb.push_back(e);
    endtask

    task automatic exp_rfw(input int c, input logic [31:0] i, input logic [31:0] d, input logic pc);
        ev_t e; e.kind = 1; e.cyc = c; e.a = i; e.d = d; e.pc = pc; sb.push_back(e);
    endtask

    task automatic exp_done(input int c);
        ev_t e; e.kind = 2; e.cyc = c; e.a = '0; e.d = '0; e.pc = 1'b0; sb.push_back(e);
    endtask

    // Issue one instruction and consume the scoreboard as DUT events appear
    task automatic run_seq(input string name, input logic [6:0] op, input logic [8:0] list,
                           input logic [2:0] rn, input logic [31:0] base, input int budget,
                           input int rst_cyc, input int restart_cyc);
        ev_t e;
        bit  finished = 0;
        @(negedge clk);
        start = 1'b1; op_code = op; reg_list = list; rn_idx = rn; base_val = base;
        #1;
        tests++;
        if (busy !== 1'b1) begin
            fails++; $display("FAIL %s busy_on_start: got %b required 1", name, busy);
        end
        @(posedge clk);
        #1 start = 1'b0; op_code = '0; reg_list = '0;
        for (int cyc = 1; cyc <= budget && !finished; cyc++) begin
            @(negedge clk);
            if (rst_cyc > 0 && cyc == rst_cyc + 1) rst = 1'b0;
            if (restart_cyc > 0 && cyc == restart_cyc + 1) begin
                start = 1'b0; op_code = '0; reg_list = '0;
            end
            if (mif.mem_write_en) begin
                tests++;
                if (sb.size() == 0) begin
                    fails++; $display("FAIL %s unexpected_store cyc %0d: got addr=%h data=%h required none",
                                      name, cyc, mif.mem_addr, mif.mem_data_in);
                end else begin
                    e = sb.pop_front();
                    if (e.kind != 0 || e.cyc != cyc || mif.mem_addr !== e.a || mif.mem_data_in !== e.d
                        || mif.mem_op_code !== 7'b0101000) begin
                        fails++;
                        $display("FAIL %s store cyc %0d: got addr=%h data=%h op=%b required kind=%0d cyc=%0d addr=%h data=%h op=0101000",
                                 name, cyc, mif.mem_addr, mif.mem_data_in, mif.mem_op_code, e.kind, e.cyc, e.a, e.d);
                    end
                end
            end
            if (rf_we) begin
                tests++;
                if (sb.size() == 0) begin
                    fails++; $display("FAIL %s unexpected_rf_write cyc %0d: got idx=%0d data=%h required none",
                                      name, cyc, rf_wr_idx, rf_wr_data);
                end else begin
                    e = sb.pop_front();
                    if (e.kind != 1 || e.cyc != cyc || 32'(rf_wr_idx) !== e.a || rf_wr_data !== e.d
                        || pc_load !== e.pc) begin
                        fails++;
                        $display("FAIL %s rf_write cyc %0d: got idx=%0d data=%h pc_load=%b required kind=%0d cyc=%0d idx=%0d data=%h pc_load=%b",
                                 name, cyc, rf_wr_idx, rf_wr_data, pc_load, e.kind, e.cyc, e.a, e.d, e.pc);
                    end
                end
            end
            if (pc_load && !rf_we) begin
                tests++; fails++;
                $display("FAIL %s pc_load_alone cyc %0d: got 1 required 0", name, cyc);
            end
            if (done) begin
                tests++;
                finished = 1;
                if (sb.size() == 0) begin
                    fails++; $display("FAIL %s unexpected_done cyc %0d: got 1 required 0", name, cyc);
                end else begin
                    e = sb.pop_front();
                    if (e.kind != 2 || e.cyc != cyc) begin
                        fails++; $display("FAIL %s done cyc %0d: got done required kind=%0d cyc=%0d",
                                          name, cyc, e.kind, e.cyc);
                    end
                end
            end
            if (sb.size() > 0 && sb[0].cyc <= cyc) begin
                e = sb.pop_front();
                tests++; fails++;
                $display("FAIL %s missing_event cyc %0d: got nothing required kind=%0d cyc=%0d a=%h d=%h",
                         name, cyc, e.kind, e.cyc, e.a, e.d);
            end
            tests++;
            if (busy !== ((rst_cyc == 0 || cyc <= rst_cyc) ? 1'b1 : 1'b0)) begin
                fails++; $display("FAIL %s busy cyc %0d: got %b required %b", name, cyc, busy,
                                  (rst_cyc == 0 || cyc <= rst_cyc));
            end
            if (rst_cyc > 0 && cyc == rst_cyc + 1) begin
                tests++;
                if ({done, rf_we, pc_load, mif.mem_write_en} !== 4'b0 || mif.mem_addr !== 32'h0
                    || mif.mem_op_code !== OP_LW || reg_rd_idx !== 4'h0 || rf_wr_idx !== 4'h0
                    || rf_wr_data !== 32'h0 || mif.mem_data_in !== 32'h0) begin
                    fails++; $display("FAIL %s post_reset_outputs: got addr=%h op=%b we=%b rf_we=%b required all zero, op=0101100",
                                      name, mif.mem_addr, mif.mem_op_code, mif.mem_write_en, rf_we);
                end
            end
            if (cyc == rst_cyc) rst = 1'b1;
            if (cyc == restart_cyc) begin
                start = 1'b1; op_code = OP_PUSH; reg_list = 9'h0FF; base_val = 32'h1000;
            end
        end
        rst = 1'b0; start = 1'b0;
        if (rst_cyc == 0) begin
            tests++;
            if (!finished) begin
                fails++; $display("FAIL %s timeout: got no done in %0d cycles required done", name, budget);
            end else begin
                @(negedge clk);
                tests++;
                if (busy !== 1'b0) begin
                    fails++; $display("FAIL %s busy_after_done: got %b required 0", name, busy);
                end
            end
        end
        tests++;
        if (sb.size() != 0) begin
            fails++; $display("FAIL %s leftover: got %0d pending events required 0", name, sb.size());
        end
        sb.delete();
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        tests++;
        if ({busy, done, rf_we, pc_load, mif.mem_write_en} !== 5'b0) begin
            fails++; $display("FAIL reset_ctrl: got %b required 00000",
                              {busy, done, rf_we, pc_load, mif.mem_write_en});
        end
        tests++;
        if (mif.mem_op_code !== OP_LW || mif.mem_addr !== 32'h0) begin
            fails++; $display("FAIL reset_mem: got op=%b addr=%h required op=0101100 addr=0",
                              mif.mem_op_code, mif.mem_addr);
        end
        tests++;
        if ({reg_rd_idx, rf_wr_idx} !== 8'h0 || rf_wr_data !== 32'h0 || mif.mem_data_in !== 32'h0) begin
            fails++; $display("FAIL reset_data: got rd=%0d wr=%0d wdata=%h din=%h required 0",
                              reg_rd_idx, rf_wr_idx, rf_wr_data, mif.mem_data_in);
        end
        rst = 1'b0;
    endtask

    task automatic test_push;
        poke_rf(4'd0, 32'hA); poke_rf(4'd2, 32'hB); poke_rf(4'd14, 32'hC);
        exp_memw(1, 32'hF4, 32'hA); exp_memw(2, 32'hF8, 32'hB); exp_memw(3, 32'hFC, 32'hC);
        exp_rfw(4, 13, 32'hF4, 1'b0); exp_done(4);
        run_seq("push", OP_PUSH, 9'h105, 3'd0, 32'h100, 10, 0, 0);
    endtask

    task automatic test_pop;
        poke_mem(32'hF4, 32'h11); poke_mem(32'hF8, 32'h2000);
        exp_rfw(2, 1, 32'h11, 1'b0); exp_rfw(3, 15, 32'h2000, 1'b1);
        exp_rfw(4, 13, 32'hFC, 1'b0); exp_done(4);
        run_seq("pop", OP_POP, 9'h102, 3'd0, 32'hF4, 10, 0, 0);
    endtask

    task automatic test_ldm;
        poke_rf(4'd2, 32'h80); poke_mem(32'h80, 32'h5); poke_mem(32'h84, 32'h6);
        exp_rfw(2, 2, 32'h5, 1'b0); exp_rfw(3, 3, 32'h6, 1'b0); exp_done(4);
        run_seq("ldm_rn_in_list", 7'b1100101, 9'h00C, 3'd2, 32'h80, 10, 0, 0);
    endtask

    task automatic test_stm;
        poke_rf(4'd1, 32'h40); poke_rf(4'd4, 32'hDEAD);
        exp_memw(1, 32'h40, 32'hDEAD); exp_rfw(2, 1, 32'h44, 1'b0); exp_done(2);
        run_seq("stm_bit8_ignored", 7'b1100000, 9'h110, 3'd1, 32'h40, 10, 0, 0);
    endtask

    task automatic test_reset_mid;
        for (int i = 0; i < 4; i++) poke_rf(4'(i), 32'h10 + 32'(i));
        poke_rf(4'd13, 32'h200);
        exp_memw(1, 32'h1F0, 32'h10); exp_memw(2, 32'h1F4, 32'h11);
        run_seq("push_reset", OP_PUSH, 9'h00F, 3'd0, 32'h200, 6, 2, 0);
        tests++;
        if (rf[13] !== 32'h200) begin
            fails++; $display("FAIL push_reset_sp: got %h required 00000200", rf[13]);
        end
    endtask

    task automatic test_back_to_back;
        poke_rf(4'd5, 32'h55); poke_rf(4'd6, 32'h66);
        exp_memw(1, 32'h2F8, 32'h55); exp_memw(2, 32'h2FC, 32'h66);
        exp_rfw(3, 13, 32'h2F8, 1'b0); exp_done(3);
        run_seq("restart_ignored", OP_PUSH, 9'h060, 3'd0, 32'h300, 10, 0, 1);
    endtask

    task automatic test_empty;
        exp_done(1);
        run_seq("push_empty", OP_PUSH, 9'h000, 3'd0, 32'h400, 5, 0, 0);
        exp_done(1);
        run_seq("ldm_only_bit8", 7'b1100100, 9'h100, 3'd0, 32'h500, 5, 0, 0);
    endtask

    task automatic test_bad_op;
        @(negedge clk);
        start = 1'b1; op_code = OP_LW; reg_list = 9'h0FF; base_val = 32'h600;
        #1;
        tests++;
        if (busy !== 1'b0) begin
            fails++; $display("FAIL bad_op_busy: got %b required 0", busy);
        end
        @(posedge clk);
        #1 start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            tests++;
            if ({busy, done, mif.mem_write_en, rf_we} !== 4'b0) begin
                fails++; $display("FAIL bad_op_idle cyc %0d: got %b required 0000", i + 1,
                                  {busy, done, mif.mem_write_en, rf_we});
            end
        end
    endtask

    task automatic test_wrap;
        poke_rf(4'd0, 32'hCAFE);
        exp_memw(1, 32'hFFFF_FFFC, 32'hCAFE); exp_rfw(2, 13, 32'hFFFF_FFFC, 1'b0); exp_done(2);
        run_seq("push_wrap", OP_PUSH, 9'h001, 3'd0, 32'h0, 6, 0, 0);
        exp_rfw(2, 0, 32'hCAFE, 1'b0); exp_rfw(3, 13, 32'h0, 1'b0); exp_done(3);
        run_seq("pop_wrap", OP_POP, 9'h001, 3'd0, 32'hFFFF_FFFC, 6, 0, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; start = 1'b0; op_code = '0; reg_list = '0; rn_idx = '0; base_val = '0;
        pm_we = 1'b0; pr_we = 1'b0; p_addr = '0; p_data = '0; p_idx = '0;
        test_reset;
        test_push;
        test_pop;
        test_ldm;
        test_stm;
        test_reset_mid;
        test_back_to_back;
        test_empty;
        test_bad_op;
        test_wrap;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
